// File: rtl/cf_spi_xfer_ctrl.sv
// Transaction sequencer for the CF_SPI byte engine: one framed half-duplex
// transfer per start (write tx_len bytes, then read rx_len bytes under one ss).
module cf_spi_xfer_ctrl #(
   parameter int unsigned LW       = 8,
   parameter int unsigned FAW      = 4,
   parameter int unsigned CS_SETUP = 2,
   parameter int unsigned CS_HOLD  = 2,
   parameter logic [7:0]  DUMMY    = 8'hFF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic [LW-1:0] tx_len,
   input  logic [LW-1:0] rx_len,
   input  logic          tx_valid,
   input  logic [7:0]    tx_data,
   output logic          tx_ready,
   output logic          rx_valid,
   output logic [7:0]    rx_data,
   input  logic          rx_ready,
   output logic          xfer_busy,
   output logic          xfer_done,
   output logic          aborted,
   output logic          spi_wr,
   output logic [7:0]    spi_datai,
   output logic          spi_rd,
   input  logic [7:0]    spi_datao,
   output logic          spi_rx_en,
   output logic          spi_tx_flush,
   output logic          spi_rx_flush,
   output logic          spi_ss,
   input  logic          spi_tx_full,
   input  logic          spi_tx_empty,
   input  logic          spi_rx_empty,
   input  logic          spi_busy
);

   localparam int unsigned CW = 16;
   localparam logic [CW-1:0] SETUP_LAST   = CW'(CS_SETUP - 1);
   localparam logic [CW-1:0] HOLD_LAST    = CW'(CS_HOLD - 1);
   // Leave one RX FIFO slot spare so a byte still shifting can always land.
   localparam logic [LW-1:0] MAX_INFLIGHT = LW'((1 << FAW) - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_FLUSH, S_SETUP, S_WRITE, S_WDRAIN,
      S_READ, S_RDRAIN, S_HOLD, S_DONE, S_ABORT
   } state_t;

   state_t        state_q, state_d;
   logic [LW-1:0] tx_len_q, tx_len_d;
   logic [LW-1:0] rx_len_q, rx_len_d;
   logic [LW-1:0] pushed_q, pushed_d, pushed_n;
   logic [LW-1:0] popped_q, popped_d, popped_n;
   logic [LW-1:0] inflight;
   logic [CW-1:0] cyc_q, cyc_d;
   logic          aborted_d;
   logic          ss_d, tx_flush_d, rx_flush_d, rx_en_d, busy_d, done_d;
   logic          push, pop;

   // State, counters and registered strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         tx_len_q     <= '0;
         rx_len_q     <= '0;
         pushed_q     <= '0;
         popped_q     <= '0;
         cyc_q        <= '0;
         aborted      <= 1'b0;
         spi_ss       <= 1'b0;
         spi_tx_flush <= 1'b0;
         spi_rx_flush <= 1'b0;
         spi_rx_en    <= 1'b0;
         xfer_busy    <= 1'b0;
         xfer_done    <= 1'b0;
      end else begin
         state_q      <= state_d;
         tx_len_q     <= tx_len_d;
         rx_len_q     <= rx_len_d;
         pushed_q     <= pushed_d;
         popped_q     <= popped_d;
         cyc_q        <= cyc_d;
         aborted      <= aborted_d;
         spi_ss       <= ss_d;
         spi_tx_flush <= tx_flush_d;
         spi_rx_flush <= rx_flush_d;
         spi_rx_en    <= rx_en_d;
         xfer_busy    <= busy_d;
         xfer_done    <= done_d;
      end
   end

   // Next state, counter updates and same-cycle FIFO handshakes
   always_comb begin
      state_d   = state_q;
      tx_len_d  = tx_len_q;
      rx_len_d  = rx_len_q;
      pushed_d  = pushed_q;
      popped_d  = popped_q;
      cyc_d     = cyc_q;
      aborted_d = aborted;
      tx_ready  = 1'b0;
      rx_valid  = 1'b0;
      rx_data   = '0;
      spi_wr    = 1'b0;
      spi_datai = '0;
      spi_rd    = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      inflight  = pushed_q - popped_q;

      if (!abort) begin
         if (state_q == S_WRITE) begin
            tx_ready = !spi_tx_full;
            if (tx_valid && !spi_tx_full) begin
               spi_wr    = 1'b1;
               spi_datai = tx_data;
               push      = 1'b1;
            end
         end
         if (state_q == S_READ && !spi_tx_full && inflight < MAX_INFLIGHT) begin
            spi_wr    = 1'b1;
            spi_datai = DUMMY;
            push      = 1'b1;
         end
         if ((state_q == S_READ || state_q == S_RDRAIN) && !spi_rx_empty) begin
            rx_valid = 1'b1;
            rx_data  = spi_datao;
            if (rx_ready) begin
               spi_rd = 1'b1;
               pop    = 1'b1;
            end
         end
      end

      pushed_n = pushed_q + LW'(push);
      popped_n = popped_q + LW'(pop);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               tx_len_d  = tx_len;
               rx_len_d  = rx_len;
               pushed_d  = '0;
               popped_d  = '0;
               cyc_d     = '0;
               aborted_d = 1'b0;
               state_d   = (tx_len == '0 && rx_len == '0) ? S_DONE : S_FLUSH;
            end
         end
         S_FLUSH: begin
            cyc_d   = '0;
            state_d = S_SETUP;
         end
         S_SETUP: begin
            if (cyc_q == SETUP_LAST) begin
               cyc_d   = '0;
               state_d = (tx_len_q != '0) ? S_WRITE : S_READ;
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end
         S_WRITE: begin
            pushed_d = pushed_n;
            if (pushed_n == tx_len_q) begin
               cyc_d   = '0;
               state_d = S_WDRAIN;
            end
         end
         S_WDRAIN: begin
            // Idle must hold two cycles: busy rises a cycle after TX FIFO pop.
            if (spi_tx_empty && !spi_busy) begin
               if (cyc_q != '0) begin
                  cyc_d = '0;
                  if (rx_len_q != '0) begin
                     pushed_d = '0;
                     state_d  = S_READ;
                  end else begin
                     state_d = S_HOLD;
                  end
               end else begin
                  cyc_d = CW'(1);
               end
            end else begin
               cyc_d = '0;
            end
         end
         S_READ: begin
            pushed_d = pushed_n;
            popped_d = popped_n;
            if (pushed_n == rx_len_q) state_d = S_RDRAIN;
         end
         S_RDRAIN: begin
            popped_d = popped_n;
            if (popped_n == rx_len_q) begin
               cyc_d   = '0;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (cyc_q == HOLD_LAST) state_d = S_DONE;
            else                    cyc_d   = cyc_q + CW'(1);
         end
         S_DONE: state_d = S_IDLE;
         S_ABORT: begin
            aborted_d = 1'b1;
            state_d   = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      if (abort && state_q != S_IDLE && state_q != S_DONE && state_q != S_ABORT)
         state_d = S_ABORT;

      ss_d       = state_d inside {S_SETUP, S_WRITE, S_WDRAIN, S_READ, S_RDRAIN, S_HOLD};
      tx_flush_d = (state_d == S_FLUSH) || (state_d == S_ABORT);
      rx_flush_d = tx_flush_d;
      rx_en_d    = (state_d == S_READ) || (state_d == S_RDRAIN);
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
   end

endmodule

// File: tb/tb_cf_spi_xfer_ctrl.sv
// Bench for cf_spi_xfer_ctrl: behavioural CF_SPI model, queue scoreboard,
// directed transfers including back-pressure, abort and mid-transfer reset.
module tb_cf_spi_xfer_ctrl;

   logic       clk, rst_n, start, abort, tx_valid, rx_ready;
   logic [7:0] tx_len, rx_len, tx_data;
   logic       tx_ready, rx_valid, xfer_busy, xfer_done, aborted;
   logic [7:0] rx_data, spi_datai, spi_datao;
   logic       spi_wr, spi_rd, spi_rx_en, spi_tx_flush, spi_rx_flush, spi_ss;
   logic       spi_tx_full, spi_tx_empty, spi_rx_empty, spi_busy;

   cf_spi_xfer_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .tx_len(tx_len), .rx_len(rx_len),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .xfer_busy(xfer_busy), .xfer_done(xfer_done), .aborted(aborted),
      .spi_wr(spi_wr), .spi_datai(spi_datai), .spi_rd(spi_rd), .spi_datao(spi_datao),
      .spi_rx_en(spi_rx_en), .spi_tx_flush(spi_tx_flush), .spi_rx_flush(spi_rx_flush),
      .spi_ss(spi_ss), .spi_tx_full(spi_tx_full), .spi_tx_empty(spi_tx_empty),
      .spi_rx_empty(spi_rx_empty), .spi_busy(spi_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard queues, filled by the stimulus
   logic [7:0] exp_wr[$];
   logic [7:0] exp_rx[$];
   logic       exp_done[$];
   logic [7:0] src_q[$];
   logic       allow_dummy;

   // CF_SPI model: 16-deep FIFOs, 4-cycle shifter, one-cycle go->busy latency
   logic [7:0] txq[$];
   logic [7:0] rxq[$];
   logic       sh_busy;
   int         sh_cnt, inflight, max_inflight, pop_cnt;
   logic       miso_mode;
   logic [7:0] miso_fixed, miso_ctr;
   logic       tx_ovf, rx_ovf, rx_full_seen, rd_underflow;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txq.delete();
         rxq.delete();
         sh_busy = 1'b0;
         sh_cnt  = 0;
         spi_tx_full  <= 1'b0;
         spi_tx_empty <= 1'b1;
         spi_rx_empty <= 1'b1;
         spi_busy     <= 1'b0;
         spi_datao    <= 8'h00;
      end else begin
         if (spi_rd) begin
            if (rxq.size() > 0) begin
               rxq.delete(0);
               pop_cnt++;
            end else rd_underflow = 1'b1;
         end
         if (spi_rx_flush) rxq.delete();
         if (spi_wr) begin
            if (txq.size() >= 16) tx_ovf = 1'b1;
            else txq.push_back(spi_datai);
         end
         if (spi_tx_flush) txq.delete();
         if (sh_busy) begin
            sh_cnt--;
            if (sh_cnt == 0) begin
               sh_busy = 1'b0;
               if (spi_rx_en) begin
                  if (rxq.size() >= 16) rx_ovf = 1'b1;
                  else rxq.push_back(miso_mode ? miso_ctr : miso_fixed);
                  miso_ctr = miso_ctr + 8'd1;
               end
            end
         end else if (txq.size() > 0) begin
            txq.delete(0);
            sh_busy = 1'b1;
            sh_cnt  = 4;
         end
         inflight = txq.size() + (sh_busy ? 1 : 0) + rxq.size();
         if (inflight > max_inflight) max_inflight = inflight;
         if (rxq.size() == 16) rx_full_seen = 1'b1;
         spi_tx_full  <= (txq.size() >= 16);
         spi_tx_empty <= (txq.size() == 0);
         spi_rx_empty <= (rxq.size() == 0);
         spi_busy     <= sh_busy;
         spi_datao    <= (rxq.size() > 0) ? rxq[0] : 8'h00;
      end
   end

   // Requester write source
   initial begin
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (src_q.size() > 0) begin
            tx_valid = 1'b1;
            tx_data  = src_q[0];
         end else tx_valid = 1'b0;
         @(negedge clk);
         if (tx_valid && tx_ready) src_q.delete(0);
      end
   end

   // Monitor: pops expectations whenever the DUT presents an event
   int   cyc, wr_cnt, rx_cnt, rd_cnt, done_cnt, ss_rises;
   int   ss_rise_cyc, ss_fall_cyc, first_wr_cyc, done_cyc;
   logic ss_prev, flush_seen;
   logic [7:0] e8;
   logic       e1;

   initial begin
      cyc = 0;
      ss_prev = 1'b0;
   end

   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (spi_wr) begin
            wr_cnt++;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            if (exp_wr.size() > 0) begin
               e8 = exp_wr.pop_front();
               chk("spi_datai", 32'(spi_datai), 32'(e8));
            end else if (allow_dummy) chk("dummy_datai", 32'(spi_datai), 32'hFF);
            else chk("unexpected_wr", 32'(spi_wr), 32'd0);
         end
         if (rx_valid && rx_ready) begin
            rx_cnt++;
            if (exp_rx.size() > 0) begin
               e8 = exp_rx.pop_front();
               chk("rx_data", 32'(rx_data), 32'(e8));
            end else chk("unexpected_rx", 32'(rx_valid), 32'd0);
         end
         if (xfer_done) begin
            done_cnt++;
            done_cyc = cyc;
            if (exp_done.size() > 0) begin
               e1 = exp_done.pop_front();
               chk("aborted_at_done", 32'(aborted), 32'(e1));
            end else chk("unexpected_done", 32'(xfer_done), 32'd0);
         end
         if (spi_rd) rd_cnt++;
         if (spi_ss && !ss_prev) begin
            ss_rises++;
            ss_rise_cyc = cyc;
         end
         if (!spi_ss && ss_prev) ss_fall_cyc = cyc;
         if (spi_tx_flush || spi_rx_flush) flush_seen = 1'b1;
      end
      ss_prev = spi_ss;
   end

   task automatic clear_stats();
      wr_cnt = 0; rx_cnt = 0; rd_cnt = 0; done_cnt = 0; ss_rises = 0;
      ss_rise_cyc = 0; ss_fall_cyc = 0; first_wr_cyc = -1; done_cyc = 0;
      flush_seen = 1'b0; max_inflight = 0; pop_cnt = 0; rx_full_seen = 1'b0;
   endtask

   task automatic do_start(input logic [7:0] tl, input logic [7:0] rl);
      @(posedge clk); #1;
      tx_len = tl;
      rx_len = rl;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("done_in_budget", 32'(done_cnt >= target), 32'd1);
      @(negedge clk);
   endtask

   task automatic chk_sb_empty(input string tag);
      chk({tag, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
      chk({tag, "_rx_left"}, 32'(exp_rx.size()), 32'd0);
      chk({tag, "_done_left"}, 32'(exp_done.size()), 32'd0);
   endtask

   logic [31:0] out_vec;
   always_comb out_vec = 32'({spi_ss, xfer_busy, xfer_done, aborted, tx_ready, rx_valid, spi_wr,
                              spi_rd, spi_rx_en, spi_tx_flush, spi_rx_flush, spi_datai, rx_data});

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b1; start = 1'b0; abort = 1'b0; tx_len = 8'd0; rx_len = 8'd0; rx_ready = 1'b1;
      miso_mode = 1'b0; miso_fixed = 8'hA5; miso_ctr = 8'd0; allow_dummy = 1'b0;
      tx_ovf = 1'b0; rx_ovf = 1'b0; rd_underflow = 1'b0;
      clear_stats();
      #2 rst_n = 1'b0;
      #1 chk("reset_outputs", out_vec, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Single command byte, no read
      clear_stats();
      src_q.push_back(8'h9F);
      exp_wr.push_back(8'h9F);
      exp_done.push_back(1'b0);
      do_start(8'd1, 8'd0);
      wait_done(1, 200);
      chk("t1_wr_cnt", 32'(wr_cnt), 32'd1);
      chk("t1_rd_cnt", 32'(rd_cnt), 32'd0);
      chk("t1_ss_setup", 32'(first_wr_cyc - ss_rise_cyc), 32'd2);
      chk("t1_done_at_ss_fall", 32'(done_cyc), 32'(ss_fall_cyc));
      chk("t1_ss_pulses", 32'(ss_rises), 32'd1);
      chk_sb_empty("t1");

      // Four-byte command then eight-byte read of 0xA5
      clear_stats();
      foreach (src_q[i]) src_q.delete(i);
      src_q.push_back(8'h03); src_q.push_back(8'h00); src_q.push_back(8'h10); src_q.push_back(8'h00);
      exp_wr.push_back(8'h03); exp_wr.push_back(8'h00); exp_wr.push_back(8'h10); exp_wr.push_back(8'h00);
      for (int i = 0; i < 8; i++) begin
         exp_wr.push_back(8'hFF);
         exp_rx.push_back(8'hA5);
      end
      exp_done.push_back(1'b0);
      do_start(8'd4, 8'd8);
      wait_done(1, 500);
      chk("t2_wr_cnt", 32'(wr_cnt), 32'd12);
      chk("t2_rx_cnt", 32'(rx_cnt), 32'd8);
      chk("t2_rd_cnt", 32'(rd_cnt), 32'd8);
      chk("t2_ss_pulses", 32'(ss_rises), 32'd1);
      chk("t2_model_rx_left", 32'(rxq.size()), 32'd0);
      chk_sb_empty("t2");

      // Forty-byte read with requester stalled for 500 cycles
      clear_stats();
      miso_mode = 1'b1;
      miso_ctr  = 8'd0;
      rx_ready  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         exp_wr.push_back(8'hFF);
         exp_rx.push_back(8'(i));
      end
      exp_done.push_back(1'b0);
      do_start(8'd0, 8'd40);
      repeat (500) @(negedge clk);
      chk("t3_inflight_cap", 32'(max_inflight), 32'd15);
      chk("t3_rx_before_ready", 32'(rx_cnt), 32'd0);
      chk("t3_busy_stalled", 32'(xfer_busy), 32'd1);
      @(posedge clk); #1 rx_ready = 1'b1;
      wait_done(1, 1000);
      chk("t3_rx_cnt", 32'(rx_cnt), 32'd40);
      chk("t3_inflight_final", 32'(max_inflight), 32'd15);
      chk("t3_rx_full_seen", 32'(rx_full_seen), 32'd0);
      chk("t3_rx_ovf", 32'(rx_ovf), 32'd0);
      chk_sb_empty("t3");

      // Abort after three received bytes
      clear_stats();
      miso_mode   = 1'b0;
      allow_dummy = 1'b1;
      for (int i = 0; i < 3; i++) exp_rx.push_back(8'hA5);
      exp_done.push_back(1'b1);
      do_start(8'd0, 8'd10);
      n = 0;
      while (pop_cnt < 3 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("t5_three_popped", 32'(pop_cnt), 32'd3);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      chk("t5_tx_flush", 32'(spi_tx_flush), 32'd1);
      chk("t5_rx_flush", 32'(spi_rx_flush), 32'd1);
      chk("t5_ss_dropped", 32'(spi_ss), 32'd0);
      chk("t5_rx_valid_off", 32'(rx_valid), 32'd0);
      wait_done(1, 20);
      repeat (10) @(negedge clk);
      allow_dummy = 1'b0;
      chk("t5_aborted_level", 32'(aborted), 32'd1);
      chk("t5_rx_cnt", 32'(rx_cnt), 32'd3);
      chk("t5_ss_pulses", 32'(ss_rises), 32'd1);
      chk_sb_empty("t5");

      // Zero-length transfer: clears aborted, no ss, no flush
      clear_stats();
      exp_done.push_back(1'b0);
      do_start(8'd0, 8'd0);
      @(negedge clk);
      chk("t4_aborted_cleared", 32'(aborted), 32'd0);
      chk("t4_done_pulse", 32'(xfer_done), 32'd1);
      chk("t4_busy_at_done", 32'(xfer_busy), 32'd1);
      @(negedge clk);
      chk("t4_done_low", 32'(xfer_done), 32'd0);
      chk("t4_busy_low", 32'(xfer_busy), 32'd0);
      chk("t4_ss_never", 32'(ss_rises), 32'd0);
      chk("t4_no_flush", 32'(flush_seen), 32'd0);
      chk_sb_empty("t4");

      // Reset asserted while the write phase is stalled
      clear_stats();
      src_q.push_back(8'h11); src_q.push_back(8'h22);
      exp_wr.push_back(8'h11); exp_wr.push_back(8'h22);
      do_start(8'd4, 8'd0);
      n = 0;
      while (wr_cnt < 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk("t6_in_write", 32'(tx_ready), 32'd1);
      @(posedge clk); #3 rst_n = 1'b0;
      #1 chk("t6_async_reset_outputs", out_vec, 32'd0);
      chk("t6_wr_seen", 32'(wr_cnt), 32'd2);
      src_q.delete();
      exp_done.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_idle_after_reset", 32'({xfer_busy, tx_ready, spi_ss}), 32'd0);

      clear_stats();
      miso_mode = 1'b1;
      miso_ctr  = 8'd0;
      src_q.push_back(8'hDE); src_q.push_back(8'hAD);
      exp_wr.push_back(8'hDE); exp_wr.push_back(8'hAD);
      for (int i = 0; i < 3; i++) begin
         exp_wr.push_back(8'hFF);
         exp_rx.push_back(8'(i));
      end
      exp_done.push_back(1'b0);
      do_start(8'd2, 8'd3);
      wait_done(1, 300);
      chk("t6_wr_cnt", 32'(wr_cnt), 32'd5);
      chk("t6_rx_cnt", 32'(rx_cnt), 32'd3);
      chk("t6_aborted", 32'(aborted), 32'd0);
      chk_sb_empty("t6");

      chk("tx_fifo_overflow", 32'(tx_ovf), 32'd0);
      chk("rx_fifo_underflow", 32'(rd_underflow), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
